// File: rtl/priority_display_scheduler_pkg.sv
// Shared constants for the priority display scheduler: FSM encoding,
// selection modes and requester count.
package priority_display_scheduler_pkg;

    localparam int N = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick8.sv
// Combinational 8-way picker: wrapped downward search from start (round-robin)
// or plain highest-set-bit search (fixed priority).
module rr_pick8
    import priority_display_scheduler_pkg::*;
(
    input  logic [N-1:0] pending,
    input  logic [2:0]   start,
    input  logic         mode,
    output logic         found,
    output logic [2:0]   idx
);

    logic [2:0] base;

    assign base = (mode == MODE_RR) ? start : 3'd7;

    always_comb begin
        logic [2:0] probe;
        found = 1'b0;
        idx   = '0;
        probe = '0;
        for (int i = 0; i < N; i++) begin
            probe = base - 3'(i);
            if (!found && pending[probe]) begin
                found = 1'b1;
                idx   = probe;
            end
        end
    end

endmodule

// File: rtl/priority_display_scheduler.sv
// Time-shares the encoder/7-segment path among 8 sticky requests, holding each
// grant for HOLD_CYCLES enabled cycles followed by a one-cycle blank.
//
// state | meaning
// IDLE  | no grant; waiting for a pending request while enabled
// SHOW  | grant driven; dwell counter running down
// GAP   | one blank cycle so the decoder shows no_data
module priority_display_scheduler
    import priority_display_scheduler_pkg::*;
#(
    parameter int HOLD_CYCLES = 10000
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         clear,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic [2:0]   grant_idx,
    output logic [N-1:0] pending
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       last_ptr;
    logic             expire;
    logic [N-1:0]     done_mask;
    logic             pick_found;
    logic [2:0]       pick_idx;
    logic [2:0]       rr_start;

    assign expire      = ena && (state == SHOW) && (counter == '0);
    assign done_mask   = expire ? grant : '0;
    assign grant_valid = |grant;
    assign rr_start    = last_ptr - 3'd1;

    rr_pick8 u_pick (
        .pending (pending),
        .start   (rr_start),
        .mode    (mode),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // A request arriving in the expiry cycle re-sets its bit, so set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (clear) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~done_mask) | req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            counter   <= '0;
            last_ptr  <= '0;
        end else if (clear) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            counter   <= '0;
        end else if (ena) begin
            case (state)
                // GAP selects on its way through IDLE so the blank is exactly one cycle.
                IDLE, GAP: begin
                    if (pick_found) begin
                        grant     <= ONE_HOT0 << pick_idx;
                        grant_idx <= pick_idx;
                        counter   <= CNT_LOAD;
                        last_ptr  <= pick_idx;
                        state     <= SHOW;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHOW: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        grant     <= '0;
                        grant_idx <= '0;
                        state     <= GAP;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    grant_idx <= '0;
                    counter   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_display_scheduler.sv
// Directed self-checking bench for priority_display_scheduler with HOLD_CYCLES=4.
module tb_priority_display_scheduler;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] req;
    logic       mode;
    logic       clear;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] pending;

    int checks   = 0;
    int failures = 0;

    priority_display_scheduler #(.HOLD_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .req         (req),
        .mode        (mode),
        .clear       (clear),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] i);
        chk({tag, "_grant"}, grant, g);
        chk({tag, "_idx"}, {5'd0, grant_idx}, {5'd0, i});
        chk({tag, "_valid"}, {7'd0, grant_valid}, {7'd0, (g != 8'h00)});
    endtask

    task automatic expect_hold(input string tag, input logic [7:0] g, input logic [2:0] i, input int n);
        for (int k = 0; k < n; k++) begin
            chk_grant(tag, g, i);
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        clear = 1'b0;
        ena   = 1'b1;
        mode  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        req   = 8'h00;
        mode  = 1'b0;
        clear = 1'b0;
        tick();
        chk_grant("rst_init", 8'h00, 3'd0);
        chk("rst_init_pend", pending, 8'h00);
        rst_n = 1'b1;

        // Reset asserted mid-SHOW with all requests high
        req = 8'hFF;
        tick();
        chk("rst_pend_ff", pending, 8'hFF);
        tick();
        chk_grant("rst_first", 8'h80, 3'd7);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_grant("rst_async", 8'h00, 3'd0);
        chk("rst_async_pend", pending, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rel_pend", pending, 8'hFF);
        chk_grant("rst_rel_nogrant", 8'h00, 3'd0);
        tick();
        chk_grant("rst_rel_grant", 8'h80, 3'd7);

        // Fixed priority, one-cycle pulse of two requests
        do_reset();
        req = 8'h24;
        tick();
        req = 8'h00;
        chk("fp_pend", pending, 8'h24);
        chk_grant("fp_lat", 8'h00, 3'd0);
        tick();
        expect_hold("fp_g20", 8'h20, 3'd5, 4);
        chk_grant("fp_gap1", 8'h00, 3'd0);
        chk("fp_gap1_pend", pending, 8'h04);
        tick();
        expect_hold("fp_g04", 8'h04, 3'd2, 4);
        chk_grant("fp_gap2", 8'h00, 3'd0);
        chk("fp_gap2_pend", pending, 8'h00);
        tick();
        chk_grant("fp_idle", 8'h00, 3'd0);
        chk("fp_idle_pend", pending, 8'h00);

        // Round-robin between bits 7 and 0
        do_reset();
        mode = 1'b1;
        req  = 8'h81;
        tick();
        tick();
        expect_hold("rr_a", 8'h80, 3'd7, 4);
        chk_grant("rr_gap_a", 8'h00, 3'd0);
        tick();
        expect_hold("rr_b", 8'h01, 3'd0, 4);
        chk_grant("rr_gap_b", 8'h00, 3'd0);
        tick();
        expect_hold("rr_c", 8'h80, 3'd7, 4);
        chk_grant("rr_gap_c", 8'h00, 3'd0);
        tick();
        expect_hold("rr_d", 8'h01, 3'd0, 4);
        req = 8'h00;

        // Held request survives its own expiry
        do_reset();
        req = 8'h20;
        tick();
        tick();
        expect_hold("sbc_g", 8'h20, 3'd5, 4);
        chk("sbc_pend", pending, 8'h20);
        chk_grant("sbc_gap", 8'h00, 3'd0);
        tick();
        chk_grant("sbc_regrant", 8'h20, 3'd5);
        req = 8'h00;

        // Freeze during SHOW
        do_reset();
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        chk_grant("frz_c3", 8'h08, 3'd3);
        tick();
        chk_grant("frz_c2", 8'h08, 3'd3);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            req = (k == 3) ? 8'h02 : 8'h00;
            tick();
            chk_grant("frz_hold", 8'h08, 3'd3);
        end
        req = 8'h00;
        chk("frz_pend", pending, 8'h0A);
        ena = 1'b1;
        expect_hold("frz_rest", 8'h08, 3'd3, 3);
        chk_grant("frz_gap", 8'h00, 3'd0);
        chk("frz_gap_pend", pending, 8'h02);
        tick();
        chk_grant("frz_next", 8'h02, 3'd1);

        // Clear in the second SHOW cycle discards everything, including same-cycle req
        do_reset();
        req = 8'h0F;
        tick();
        req = 8'h00;
        tick();
        chk_grant("clr_s1", 8'h08, 3'd3);
        tick();
        chk_grant("clr_s2", 8'h08, 3'd3);
        clear = 1'b1;
        req   = 8'h10;
        tick();
        clear = 1'b0;
        req   = 8'h00;
        chk_grant("clr_after", 8'h00, 3'd0);
        chk("clr_pend", pending, 8'h00);
        tick();
        chk_grant("clr_idle", 8'h00, 3'd0);
        chk("clr_idle_pend", pending, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
